// File: rtl/mem_arbiter_pkg.sv
// Shared types for the L1-to-RAM memory arbiter: RAM handshake state, the
// 32-bit data word, the arbiter FSM state, and a small index-width helper.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  // Status reported by the RAM model/bus on every cycle.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM states; the top maps these onto legacy 2-bit constants.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_D = 2'd1,
    ARB_SERVE_I = 2'd2
  } arb_state_t;

  // Bits needed to index n cores (never less than 1).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus between the per-core L1 caches, the arbiter and the RAM.
// slave  : arbiter view (takes cache requests and RAM status, drives waits,
//          loads and RAM strobes).
// master : cache/RAM side view (the environment around the arbiter).
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES = 2
);

  // cache side, one lane per core
  logic [NCORES-1:0]  iREN;
  word_t [NCORES-1:0] iaddr;
  logic [NCORES-1:0]  iwait;
  word_t [NCORES-1:0] iload;
  logic [NCORES-1:0]  dREN;
  logic [NCORES-1:0]  dWEN;
  word_t [NCORES-1:0] daddr;
  word_t [NCORES-1:0] dstore;
  logic [NCORES-1:0]  dwait;
  word_t [NCORES-1:0] dload;

  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  // watchdog abort pulse
  logic timeout;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           timeout
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
           timeout
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: returns the first requesting lane at or after ptr,
// scanning upward and wrapping. Purely combinational; the arbiter uses one
// instance per request class (data and instruction) sharing one pointer.
module mem_arbiter_rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES = 2,
  parameter int IDXW   = 1
) (
  input  logic [NCORES-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  output logic              valid,
  output logic [IDXW-1:0]   winner
);

  // Scan from the farthest lane back toward ptr so the closest requester is
  // the last one written and therefore wins.
  always_comb begin
    int lane;
    valid  = 1'b0;
    winner = ptr;
    lane   = 0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      lane = int'(ptr) + k;
      if (lane >= NCORES) begin
        lane = lane - NCORES;
      end
      if (req[lane]) begin
        valid  = 1'b1;
        winner = IDXW'(lane);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between the per-core icache/dcache memory ports and
// the single-ported RAM. Data requests beat instruction requests; cores are
// served round-robin from one pointer shared by both classes. One transfer
// is in flight at a time and every completion is followed by one idle cycle.
//
// Optional build macro: ARB_TIMEOUT_EN enables the serve watchdog (abort after
// TIMEOUT_CYCLES serve cycles without ACCESS, or after two consecutive ERROR
// cycles). Without it the arbiter waits on the RAM indefinitely and timeout
// is tied low.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no RAM strobes; pick a winner and register the grant
// SERVE_D | drive the granted data read/write until ACCESS or abort
// SERVE_I | drive the granted instruction read until ACCESS or abort
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic         CLK,
  input logic         nRST,
  mem_arbiter_if.slave bus
);

  localparam int IDXW = idx_width(NCORES);

  localparam logic [1:0] IDLE    = ARB_IDLE;
  localparam logic [1:0] SERVE_D = ARB_SERVE_D;
  localparam logic [1:0] SERVE_I = ARB_SERVE_I;

  logic [1:0]        state;
  logic [IDXW-1:0]   grant_core;
  logic              grant_wen;
  logic [IDXW-1:0]   rr_ptr;

  logic [NCORES-1:0] d_req;
  logic              d_valid;
  logic              i_valid;
  logic [IDXW-1:0]   d_win;
  logic [IDXW-1:0]   i_win;

  // live : granted requester still holds the granted request
  // drive: RAM strobes are asserted this cycle
  // done : this cycle completes the granted transfer
  logic              live;
  logic              drive;
  logic              done;
  logic              tmo;

  assign d_req = bus.dREN | bus.dWEN;

  mem_arbiter_rr_pick #(
    .NCORES (NCORES),
    .IDXW   (IDXW)
  ) u_pick_d (
    .req    (d_req),
    .ptr    (rr_ptr),
    .valid  (d_valid),
    .winner (d_win)
  );

  mem_arbiter_rr_pick #(
    .NCORES (NCORES),
    .IDXW   (IDXW)
  ) u_pick_i (
    .req    (bus.iREN),
    .ptr    (rr_ptr),
    .valid  (i_valid),
    .winner (i_win)
  );

  // Track whether the granted requester is still asking; a dropped request
  // (e.g. a dcache flush abort) releases the RAM in the same cycle.
  always_comb begin
    live = 1'b0;
    if (state == SERVE_D) begin
      live = grant_wen ? bus.dWEN[grant_core] : bus.dREN[grant_core];
    end else if (state == SERVE_I) begin
      live = bus.iREN[grant_core];
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNTW-1:0] serve_cnt;
  logic            err_prev;

  // Fire on the last allowed serve cycle or on the second ERROR in a row;
  // an ACCESS in that same cycle still completes normally.
  assign tmo = live && (bus.ramstate != ACCESS) &&
               ((serve_cnt == CNTW'(TIMEOUT_CYCLES - 1)) ||
                ((bus.ramstate == ERROR) && err_prev));

  // Count serve cycles of the current grant; cleared while idle, i.e. on
  // every new grant.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      serve_cnt <= '0;
      err_prev  <= 1'b0;
    end else if (state == IDLE) begin
      serve_cnt <= '0;
      err_prev  <= 1'b0;
    end else begin
      serve_cnt <= serve_cnt + 1'b1;
      err_prev  <= (bus.ramstate == ERROR);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  assign drive       = live && !tmo;
  assign done        = drive && (bus.ramstate == ACCESS);
  assign bus.timeout = tmo;

  // Arbitration, grant register, round-robin pointer and serve/idle sequencing.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      grant_core <= '0;
      grant_wen  <= 1'b0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_valid) begin
            state      <= SERVE_D;
            grant_core <= d_win;
            grant_wen  <= bus.dWEN[d_win];
          end else if (i_valid) begin
            state      <= SERVE_I;
            grant_core <= i_win;
            grant_wen  <= 1'b0;
          end
        end
        SERVE_D, SERVE_I: begin
          if (done) begin
            state  <= IDLE;
            rr_ptr <= (grant_core == IDXW'(NCORES - 1)) ? '0
                                                        : grant_core + 1'b1;
          end else if (!drive) begin
            // abort or watchdog: release without moving the pointer
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port: strobes, address and write data from the registered grant.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    if (drive) begin
      if (state == SERVE_D) begin
        bus.ramaddr = bus.daddr[grant_core];
        if (grant_wen) begin
          bus.ramWEN   = 1'b1;
          bus.ramstore = bus.dstore[grant_core];
        end else begin
          bus.ramREN = 1'b1;
        end
      end else begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr[grant_core];
      end
    end
  end

  // Completion: release exactly the granted wait for one cycle and return
  // read data on that requester's load bus.
  always_comb begin
    bus.iwait = '1;
    bus.dwait = '1;
    bus.iload = '0;
    bus.dload = '0;
    if (done) begin
      if (state == SERVE_D) begin
        bus.dwait[grant_core] = 1'b0;
        if (!grant_wen) begin
          bus.dload[grant_core] = bus.ramload;
        end
      end else begin
        bus.iwait[grant_core] = 1'b0;
        bus.iload[grant_core] = bus.ramload;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized cache/RAM traffic checked every cycle against a transaction-level
// model (one in-flight transfer, integer round-robin pointer).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N = 2;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  mem_arbiter_if #(.NCORES(N)) bus ();

  mem_arbiter #(
    .NCORES         (N),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // model: at most one transfer in flight
  bit         m_busy = 1'b0;
  int         m_core = 0;
  bit         m_isd  = 1'b0;
  bit         m_wr   = 1'b0;
  int         m_rr   = 0;
  bit [N-1:0] m_idone = '0;
  bit [N-1:0] m_ddone = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic bit m_live();
    if (!m_busy) return 1'b0;
    if (m_isd) return m_wr ? bus.dWEN[m_core] : bus.dREN[m_core];
    return bus.iREN[m_core];
  endfunction

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    bit         lv;
    bit         dn;
    word_t      ea;
    word_t      es;
    logic [N-1:0] eiw;
    logic [N-1:0] edw;
    bit [N-1:0] idn;
    bit [N-1:0] ddn;
    lv  = m_live();
    dn  = lv && (bus.ramstate == ACCESS);
    ea  = '0;
    es  = '0;
    if (lv) ea = m_isd ? bus.daddr[m_core] : bus.iaddr[m_core];
    if (lv && m_isd && m_wr) es = bus.dstore[m_core];
    eiw = '1;
    edw = '1;
    idn = '0;
    ddn = '0;
    if (dn) begin
      if (m_isd) begin
        edw[m_core] = 1'b0;
        ddn[m_core] = 1'b1;
      end else begin
        eiw[m_core] = 1'b0;
        idn[m_core] = 1'b1;
      end
    end
    chk("m_ramREN", bus.ramREN, lv && !(m_isd && m_wr));
    chk("m_ramWEN", bus.ramWEN, lv && m_isd && m_wr);
    chk("m_ramaddr", bus.ramaddr, ea);
    chk("m_ramstore", bus.ramstore, es);
    chk("m_iwait", bus.iwait, eiw);
    chk("m_dwait", bus.dwait, edw);
    chk("m_timeout", bus.timeout, 1'b0);
    for (int c = 0; c < N; c++) begin
      if (idn[c]) chk("m_iload", bus.iload[c], bus.ramload);
      if (ddn[c] && !m_wr) chk("m_dload", bus.dload[c], bus.ramload);
    end
    m_idone <= idn;
    m_ddone <= ddn;
  end

  // Model state advance: completion moves the pointer past the served core,
  // a dropped request just releases, and idle picks data before instruction.
  always @(posedge CLK or negedge nRST) begin
    int w;
    if (!nRST) begin
      m_busy <= 1'b0;
      m_rr   <= 0;
    end else if (m_busy) begin
      if (m_live() && (bus.ramstate == ACCESS)) begin
        m_busy <= 1'b0;
        m_rr   <= (m_core + 1) % N;
      end else if (!m_live()) begin
        m_busy <= 1'b0;
      end
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && (bus.dREN[(m_rr + k) % N] || bus.dWEN[(m_rr + k) % N]))
          w = (m_rr + k) % N;
      end
      if (w >= 0) begin
        m_busy <= 1'b1;
        m_core <= w;
        m_isd  <= 1'b1;
        m_wr   <= bus.dWEN[w];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && bus.iREN[(m_rr + k) % N]) w = (m_rr + k) % N;
        end
        if (w >= 0) begin
          m_busy <= 1'b1;
          m_core <= w;
          m_isd  <= 1'b0;
          m_wr   <= 1'b0;
        end
      end
    end
  end

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1);
  end

  logic [N-1:0] rr_wait [6];
  word_t        rr_addr [6];
  int           r;

  initial begin
    nRST         = 1'b0;
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;

    // reset values
    at_neg();
    chk("rst_iwait", bus.iwait, 2'b11);
    chk("rst_dwait", bus.dwait, 2'b11);
    chk("rst_ramREN", bus.ramREN, 1'b0);
    chk("rst_ramWEN", bus.ramWEN, 1'b0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_iload0", bus.iload[0], 32'h0);
    chk("rst_dload1", bus.dload[1], 32'h0);
    chk("rst_timeout", bus.timeout, 1'b0);
    adv();
    nRST = 1'b1;
    adv();

    // single i-read: ACCESS after two BUSY cycles
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h40;
    bus.ramstate = FREE;
    at_neg();
    chk("t1_c0_ramREN", bus.ramREN, 1'b0);
    adv();
    bus.ramstate = BUSY;
    at_neg();
    chk("t1_c1_ramREN", bus.ramREN, 1'b1);
    chk("t1_c1_ramaddr", bus.ramaddr, 32'h40);
    chk("t1_c1_iwait", bus.iwait, 2'b11);
    adv();
    at_neg();
    chk("t1_c2_ramREN", bus.ramREN, 1'b1);
    adv();
    bus.ramstate = ACCESS;
    bus.ramload  = 32'hDEADBEEF;
    at_neg();
    chk("t1_c3_ramREN", bus.ramREN, 1'b1);
    chk("t1_c3_iwait", bus.iwait, 2'b10);
    chk("t1_c3_iload0", bus.iload[0], 32'hDEADBEEF);
    adv();
    bus.iREN[0]  = 1'b0;
    bus.ramstate = FREE;
    at_neg();
    chk("t1_c4_ramREN", bus.ramREN, 1'b0);
    adv();

    // priority: core1 write beats core0 i-read raised in the same cycle
    bus.iREN[0]   = 1'b1;
    bus.iaddr[0]  = 32'h80;
    bus.dWEN[1]   = 1'b1;
    bus.daddr[1]  = 32'h100;
    bus.dstore[1] = 32'h1234;
    at_neg();
    chk("t2_c0_ramWEN", bus.ramWEN, 1'b0);
    adv();
    bus.ramstate = ACCESS;
    at_neg();
    chk("t2_c1_ramWEN", bus.ramWEN, 1'b1);
    chk("t2_c1_ramREN", bus.ramREN, 1'b0);
    chk("t2_c1_ramaddr", bus.ramaddr, 32'h100);
    chk("t2_c1_ramstore", bus.ramstore, 32'h1234);
    chk("t2_c1_dwait", bus.dwait, 2'b01);
    chk("t2_c1_iwait", bus.iwait, 2'b11);
    adv();
    bus.dWEN[1] = 1'b0;
    at_neg();
    chk("t2_c2_ramREN", bus.ramREN, 1'b0);
    chk("t2_c2_ramWEN", bus.ramWEN, 1'b0);
    adv();
    at_neg();
    chk("t2_c3_ramREN", bus.ramREN, 1'b1);
    chk("t2_c3_ramaddr", bus.ramaddr, 32'h80);
    chk("t2_c3_iwait", bus.iwait, 2'b10);
    adv();
    bus.iREN[0]  = 1'b0;
    bus.ramstate = FREE;
    adv();

    // abort: pointer now at core1; core1 drops its read before ACCESS
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h300;
    bus.ramstate = BUSY;
    at_neg();
    chk("t3_c0_ramREN", bus.ramREN, 1'b0);
    adv();
    at_neg();
    chk("t3_c1_ramREN", bus.ramREN, 1'b1);
    chk("t3_c1_ramaddr", bus.ramaddr, 32'h300);
    adv();
    bus.dREN[1]  = 1'b0;
    bus.ramstate = ACCESS;
    at_neg();
    chk("t3_c2_ramREN", bus.ramREN, 1'b0);
    chk("t3_c2_dwait", bus.dwait, 2'b11);
    adv();
    bus.dREN     = 2'b11;
    bus.daddr[0] = 32'h400;
    bus.daddr[1] = 32'h300;
    at_neg();
    chk("t3_c3_ramREN", bus.ramREN, 1'b0);
    adv();
    at_neg();
    chk("t3_c4_ramaddr", bus.ramaddr, 32'h300);
    chk("t3_c4_dwait", bus.dwait, 2'b01);
    adv();
    // core0 still pending: it is served next, then everything drops
    at_neg();
    chk("t3_c5_ramREN", bus.ramREN, 1'b0);
    adv();
    bus.dREN[1] = 1'b0;
    at_neg();
    chk("t3_c6_ramaddr", bus.ramaddr, 32'h400);
    chk("t3_c6_dwait", bus.dwait, 2'b10);
    adv();
    bus.dREN     = '0;
    bus.ramstate = FREE;
    adv();

    // round-robin: pointer at core1 after the core0 completion above; both
    // cores hold dREN with instant ACCESS
    rr_wait = '{2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
    rr_addr = '{32'h0, 32'h201, 32'h0, 32'h200, 32'h0, 32'h201};
    bus.dREN     = 2'b11;
    bus.daddr[0] = 32'h200;
    bus.daddr[1] = 32'h201;
    bus.ramstate = ACCESS;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("t4_dwait", bus.dwait, rr_wait[k]);
      chk("t4_ramaddr", bus.ramaddr, rr_addr[k]);
      adv();
    end
    bus.dREN     = '0;
    bus.ramstate = FREE;
    adv();

    // reset in the middle of a write transfer
    bus.dWEN[0]   = 1'b1;
    bus.daddr[0]  = 32'h500;
    bus.dstore[0] = 32'hAAAA;
    bus.ramstate  = BUSY;
    at_neg();
    chk("t5_c0_ramWEN", bus.ramWEN, 1'b0);
    adv();
    at_neg();
    chk("t5_c1_ramWEN", bus.ramWEN, 1'b1);
    #1;
    nRST = 1'b0;
    #1;
    chk("t5_rst_ramWEN", bus.ramWEN, 1'b0);
    chk("t5_rst_ramaddr", bus.ramaddr, 32'h0);
    chk("t5_rst_ramstore", bus.ramstore, 32'h0);
    chk("t5_rst_dwait", bus.dwait, 2'b11);
    chk("t5_rst_iwait", bus.iwait, 2'b11);
    adv();
    adv();
    nRST = 1'b1;
    at_neg();
    chk("t5_rel_ramWEN", bus.ramWEN, 1'b0);
    adv();
    bus.ramstate = ACCESS;
    at_neg();
    chk("t5_serve_ramWEN", bus.ramWEN, 1'b1);
    chk("t5_serve_dwait", bus.dwait, 2'b10);
    adv();
    bus.dWEN[0]  = 1'b0;
    bus.ramstate = FREE;
    adv();

    // randomized traffic against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (bus.iREN[c] && m_idone[c]) bus.iREN[c] = 1'b0;
        if (!bus.iREN[c] && $urandom_range(3) == 0) begin
          bus.iREN[c]  = 1'b1;
          bus.iaddr[c] = $urandom;
        end
        if ((bus.dREN[c] || bus.dWEN[c]) &&
            (m_ddone[c] || $urandom_range(40) == 0)) begin
          bus.dREN[c] = 1'b0;
          bus.dWEN[c] = 1'b0;
        end else if (!(bus.dREN[c] || bus.dWEN[c]) &&
                     $urandom_range(2) == 0) begin
          if ($urandom_range(1) == 1) bus.dWEN[c] = 1'b1;
          else                        bus.dREN[c] = 1'b1;
          bus.daddr[c]  = $urandom;
          bus.dstore[c] = $urandom;
        end
      end
      r = int'($urandom_range(9));
      bus.ramstate = (r < 4) ? ACCESS : (r < 6) ? BUSY : (r < 8) ? FREE : ERROR;
      bus.ramload  = $urandom;
      adv();
    end

    at_neg();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shared-memory request arbiter between the per-core L1 caches (icache and dcache of each core) and the single-ported RAM.
- Chooses one pending request, drives the RAM port until RAM reports ACCESS, returns the word to that requester and releases its wait.
- Sits between the caches_if memory side of every core and the RAM model/bus.
- Data requests beat instruction requests. Cores are served round-robin.

Parameters:
- NCORES, 2, number of cores; each core has one i-requester and one d-requester; legal range 2..4.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  NCORES  instruction read request, per core
- iaddr  in  NCORES*32  instruction word address, per core
- iwait  out  NCORES  low for exactly the completion cycle of a granted i-read
- iload  out  NCORES*32  instruction data; valid when matching iwait is low
- dREN  in  NCORES  data read request, per core
- dWEN  in  NCORES  data write request, per core; dREN and dWEN are never both high
- daddr  in  NCORES*32  data word address, per core
- dstore  in  NCORES*32  write data, per core
- dwait  out  NCORES  low for exactly the completion cycle of a granted d-access
- dload  out  NCORES*32  read data; valid when matching dwait is low
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- timeout  out  1  watchdog abort pulse; tied 0 unless ARB_TIMEOUT_EN is defined

Behaviour:
Reset (async, immediate, also mid-transfer):
- state=IDLE, rr_ptr=0, grant cleared.
- ramREN=ramWEN=0, ramaddr=ramstore=0.
- All iwait/dwait=1, iload/dload=0, timeout=0.

States:
- IDLE: no RAM strobes.
  - If any request is pending, register the grant, then go to SERVE_D or SERVE_I.
  - Arbitration is 1 cycle: a request first seen in cycle N drives the RAM in cycle N+1.
- SERVE_D / SERVE_I:
  - Drive ramaddr, ramstore (writes only) and ramREN or ramWEN from the registered grant.
  - ramstate==ACCESS: drop the granted wait low for that cycle; for reads, drive ramload onto that requester's load bus. Advance rr_ptr to (granted core+1) mod NCORES. Go to IDLE.
  - FREE or BUSY: stay in the serve state.
  - ERROR: treated as BUSY (retry).

Arbitration:
- Any dREN|dWEN beats any iREN.
- Within a class, the first requesting core at or after rr_ptr wins, scanning upward with wrap-around.
- rr_ptr is shared by both classes.

Handshake rules:
- A requester holds its request and its address/data until its wait goes low.
- Wait outputs are combinational from state, grant and ramstate.
- Every non-granted requester sees wait=1.

Boundary conditions:
- Granted requester deasserts mid-transfer (e.g. a dcache flush abort): strobes drop that same cycle, return to IDLE, no wait-low pulse, rr_ptr unchanged.
- Only one completion ever occurs per ACCESS cycle.
- The cycle after a completion is always IDLE, so back-to-back grants are separated by exactly 1 idle cycle.
- A newly arriving higher-priority request never preempts an in-flight transfer.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A serve-cycle counter (width $clog2(TIMEOUT_CYCLES+1)) is cleared on each grant.
  - If the counter reaches TIMEOUT_CYCLES without ACCESS, or ramstate==ERROR for 2 consecutive cycles:
    - strobes drop;
    - timeout pulses high for 1 cycle;
    - state returns to IDLE with no wait-low pulse and rr_ptr unchanged;
    - the requester is re-arbitrated normally.
- Undefined: no counter; timeout=0 constantly; the arbiter waits indefinitely.

Decomposition:
- cpu_types_pkg holds ramstate_t, word_t, and a new arb_state_t (IDLE, SERVE_D, SERVE_I).
- One sub-module, rr_pick:
  - purely combinational;
  - inputs: NCORES request vector and rr_ptr;
  - outputs: valid and winner index.
  - Instantiated twice: once for the d class, once for the i class.

Test Plan:
- Single i-read: core0 iREN, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN high cycles 1-3; iwait[0] low only in cycle 3 with iload[0]=0xDEADBEEF.
- Priority: core0 iREN and core1 dWEN (daddr=0x100, dstore=0x1234) in the same cycle -> write served first (ramWEN, ramaddr=0x100, ramstore=0x1234), then core0's i-read.
- Round-robin: both cores hold dREN continuously, instant ACCESS each time -> grants alternate 0,1,0,1 with one IDLE cycle between completions.
- Abort: core1 dREN granted, deasserted before ACCESS -> ramREN drops the same cycle, dwait[1] never low, next grant still starts from core1's rr position.
- Reset mid-transfer: nRST low while SERVE_D with ramWEN=1 -> ramWEN=0 immediately (asynchronous); all waits 1; state IDLE after release.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ramstate held BUSY -> timeout pulses at the 8th serve cycle, strobes low, request re-granted 2 cycles later.
